gemm_row_sched: RTL
===================

GEMM_ROW_SCHED -- requirements
Module: gemm_row_sched

Interface
REQ-001 SHALL have parameter N, default 32: dot-product length (elements per vector and per matrix row).
REQ-002 SHALL have parameter EW, default 16: signed element width.
REQ-003 SHALL have parameter AW, default 81: dot-product result width.
REQ-004 SHALL have parameter DP_LAT, default 1: dot-product unit latency in cycles, 0..7.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: begin a job; sampled only in IDLE.
REQ-008 SHALL have port num_rows, input, 6: rows in the job, 0..32, sampled with start.
REQ-009 SHALL have port in_valid, input, 1: element-stream valid.
REQ-010 SHALL have port in_ready, output, 1: element-stream ready.
REQ-011 SHALL have port in_data, input, EW: signed element.
REQ-012 SHALL have port vec_bus, output, N*EW: held vector; element k at bits [k*EW +: EW], driving the vector inputs of the dot-product unit.
REQ-013 SHALL have port row_bus, output, N*EW: held matrix row, same packing, driving the matrix inputs.
REQ-014 SHALL have port dp_result, input, AW: dot-product unit output.
REQ-015 SHALL have port res_valid, output, 1: result valid.
REQ-016 SHALL have port res_ready, input, 1: result consumer ready.
REQ-017 SHALL have port res_data, output, AW: captured result.
REQ-018 SHALL have port res_row, output, 6: row index of res_data.
REQ-019 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-020 SHALL have port done, output, 1: one-cycle pulse at job end.

Function
REQ-021 SHALL implement the states IDLE, LOAD_VEC, LOAD_ROW, COMPUTE, OUTPUT, FIN.
REQ-022 SHALL, in IDLE with start=1, latch num_rows and go to LOAD_VEC when num_rows>0, else to FIN.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL assert in_ready only in LOAD_VEC and LOAD_ROW; a beat transfers when in_valid&&in_ready.
REQ-025 SHALL, in LOAD_VEC, write beat k (k=0..N-1) to vector element k; after beat N-1, clear elem count to 0 and go to LOAD_ROW.
REQ-026 SHALL, in LOAD_ROW, write beat k to row element k; after beat N-1, go to COMPUTE.
REQ-027 SHALL keep vec_bus and row_bus stable outside their load states; vec_bus is held for the whole job.
REQ-028 SHALL stay in COMPUTE for DP_LAT+1 cycles, then capture dp_result into res_data and the current row index into res_row, and go to OUTPUT.
REQ-029 SHALL assert res_valid throughout OUTPUT, holding res_data and res_row stable until res_valid&&res_ready.
REQ-030 SHALL, on handshake, go to LOAD_ROW with the row index incremented when more rows remain; after the last row it SHALL go to FIN.
REQ-031 SHALL pulse done for exactly one cycle in FIN, then return to IDLE; start in FIN is ignored.
REQ-032 SHALL store res_data unchanged at the full AW bits, with no truncation or saturation.
REQ-033 SHALL sustain in_valid stalls of any length without losing or duplicating an element.
REQ-034 SHALL treat num_rows above 32 as 32.

Reset
REQ-035 SHALL, on rst_n low, asynchronously reset to IDLE.
REQ-036 SHALL clear all counters, vec_bus, row_bus, res_data and res_row to 0 on reset.
REQ-037 SHALL drive in_ready, res_valid, busy and done to 0 on reset.
REQ-038 SHALL abort any in-progress job on reset mid-operation, producing no done pulse; the next job after reset deassertion starts cleanly.

Verification
REQ-039 Bench SHALL cover basic job: num_rows=1, vector all 1, row 1..32, dp model=sum -> res_data=528, res_row=0, done one cycle after handshake.
REQ-040 Bench SHALL cover multi-row with backpressure: num_rows=3, res_ready low 5 cycles per result -> results for rows 0,1,2 in order, each held stable while stalled.
REQ-041 Bench SHALL cover in_valid gaps: random gaps on in_valid, vector -1, row all 32767 -> res_data=-1048544, sign-extended to 81 bits.
REQ-042 Bench SHALL cover num_rows=0: start -> busy for 1 cycle, done pulse, in_ready never asserted.
REQ-043 Bench SHALL cover reset mid-job: rst_n low during LOAD_ROW beat 10 -> all outputs 0 immediately; a fresh num_rows=1 job then produces the correct result.
REQ-044 Bench SHALL cover start while busy: start pulsed in COMPUTE -> ignored, job completes unchanged, single done pulse.

Source files
------------

// File: rtl/gemm_row_sched_if.sv
// Job control, element stream and result handshake between gemm_row_sched
// and its environment (slave = scheduler, master = driver/consumer).
interface gemm_row_sched_if #(
    parameter int N  = 32,
    parameter int EW = 16,
    parameter int AW = 81
);
    logic            start;
    logic [5:0]      num_rows;
    logic            in_valid;
    logic            in_ready;
    logic [EW-1:0]   in_data;
    logic [N*EW-1:0] vec_bus;
    logic [N*EW-1:0] row_bus;
    logic [AW-1:0]   dp_result;
    logic            res_valid;
    logic            res_ready;
    logic [AW-1:0]   res_data;
    logic [5:0]      res_row;
    logic            busy;
    logic            done;

    modport slave (
        input  start, num_rows, in_valid, in_data, dp_result, res_ready,
        output in_ready, vec_bus, row_bus, res_valid, res_data, res_row, busy, done
    );

    modport master (
        output start, num_rows, in_valid, in_data, dp_result, res_ready,
        input  in_ready, vec_bus, row_bus, res_valid, res_data, res_row, busy, done
    );
endinterface

// File: rtl/gemm_row_sched.sv
// Row scheduler for a matrix-vector product: loads one vector, then streams
// matrix rows through an external dot-product unit and hands back one result per row.
module gemm_row_sched #(
    parameter int N      = 32,
    parameter int EW     = 16,
    parameter int AW     = 81,
    parameter int DP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gemm_row_sched_if.slave bus
);
    localparam int         EC_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [5:0] MAX_ROWS = 6'd32;

    typedef enum logic [2:0] {
        IDLE, LOAD_VEC, LOAD_ROW, COMPUTE, OUTPUT, FIN
    } state_t;

    state_t               r_state, w_next;
    logic [5:0]           r_rows;
    logic [5:0]           r_row_idx;
    logic [EC_W-1:0]      r_elem;
    logic [2:0]           r_lat;
    logic [N-1:0][EW-1:0] r_vec;
    logic [N-1:0][EW-1:0] r_row;
    logic [AW-1:0]        r_res_data;
    logic [5:0]           r_res_row;

    logic       w_in_ready, w_res_valid, w_busy, w_done;
    logic       w_beat, w_last_elem, w_lat_done, w_res_hs, w_more_rows;
    logic [5:0] w_rows_clamped;

    assign w_beat         = bus.in_valid && w_in_ready;
    assign w_last_elem    = (r_elem == EC_W'(N - 1));
    assign w_lat_done     = (r_lat == 3'(DP_LAT));
    assign w_res_hs       = w_res_valid && bus.res_ready;
    assign w_more_rows    = (r_row_idx + 6'd1) < r_rows;
    assign w_rows_clamped = (bus.num_rows > MAX_ROWS) ? MAX_ROWS : bus.num_rows;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.start) w_next = (w_rows_clamped != 6'd0) ? LOAD_VEC : FIN;
            LOAD_VEC: if (w_beat && w_last_elem) w_next = LOAD_ROW;
            LOAD_ROW: if (w_beat && w_last_elem) w_next = COMPUTE;
            COMPUTE:  if (w_lat_done) w_next = OUTPUT;
            OUTPUT:   if (w_res_hs) w_next = w_more_rows ? LOAD_ROW : FIN;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE:               w_busy      = 1'b0;
            LOAD_VEC, LOAD_ROW: w_in_ready  = 1'b1;
            OUTPUT:             w_res_valid = 1'b1;
            FIN:                w_done      = 1'b1;
            default: ;
        endcase
    end

    // The element counter wraps to 0 after each full vector/row so the next load starts at element 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows     <= '0;
            r_row_idx  <= '0;
            r_elem     <= '0;
            r_lat      <= '0;
            r_vec      <= '0;
            r_row      <= '0;
            r_res_data <= '0;
            r_res_row  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_rows    <= w_rows_clamped;
                    r_row_idx <= '0;
                    r_elem    <= '0;
                end
                LOAD_VEC: if (w_beat) begin
                    r_vec[r_elem] <= bus.in_data;
                    r_elem        <= w_last_elem ? '0 : r_elem + 1'b1;
                end
                LOAD_ROW: if (w_beat) begin
                    r_row[r_elem] <= bus.in_data;
                    r_elem        <= w_last_elem ? '0 : r_elem + 1'b1;
                    r_lat         <= '0;
                end
                COMPUTE: begin
                    r_lat <= r_lat + 3'd1;
                    if (w_lat_done) begin
                        r_res_data <= bus.dp_result;
                        r_res_row  <= r_row_idx;
                    end
                end
                OUTPUT: if (w_res_hs && w_more_rows) r_row_idx <= r_row_idx + 6'd1;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.vec_bus   = r_vec;
    assign bus.row_bus   = r_row;
    assign bus.res_data  = r_res_data;
    assign bus.res_row   = r_res_row;
endmodule
